// File: rtl/card_dealer_ctrl_if.sv
// Handshake bundle between the card dealer controller, its players/consumer
// and the random-card datapath.
interface card_dealer_ctrl_if #(
   parameter int N_PLAYERS = 4
);
   logic [N_PLAYERS-1:0] req_i;
   logic                 ack_i;
   logic                 shuffle_i;
   logic [7:0]           card_to_send_dp_i;
   logic                 req_card_state_dp_o;
   logic [N_PLAYERS-1:0] grant_o;
   logic [7:0]           card_o;
   logic                 card_valid_o;
   logic                 busy_o;
   logic                 deck_empty_o;
   logic [6:0]           cards_left_o;

   modport master (
      output req_i, ack_i, shuffle_i, card_to_send_dp_i,
      input  req_card_state_dp_o, grant_o, card_o, card_valid_o,
             busy_o, deck_empty_o, cards_left_o
   );

   modport slave (
      input  req_i, ack_i, shuffle_i, card_to_send_dp_i,
      output req_card_state_dp_o, grant_o, card_o, card_valid_o,
             busy_o, deck_empty_o, cards_left_o
   );
endinterface

// File: rtl/card_dealer_ctrl.sv
// Deals cards from a DECK_SIZE deck to round-robin arbitrated players, drawing
// values from a random datapath and falling back to the lowest free card.
module card_dealer_ctrl #(
   parameter int N_PLAYERS  = 4,
   parameter int DECK_SIZE  = 52,
   parameter int DP_LATENCY = 1,
   parameter int MAX_RETRY  = 255
) (
   input  logic              clk_ctl_i,
   input  logic              rst_ctl_i,
   card_dealer_ctrl_if.slave bus
);

   localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, CHECK, DELIVER} state_t;

   state_t               state, state_n;
   logic [DECK_SIZE-1:0] dealt, dealt_n;
   logic [6:0]           cards_left, cards_left_n;
   logic                 deck_empty, deck_empty_n;
   logic [N_PLAYERS-1:0] grant, grant_n;
   logic [PW-1:0]        grant_idx, grant_idx_n;
   logic [PW-1:0]        rr_ptr, rr_ptr_n;
   logic [7:0]           card, card_n;
   logic                 card_valid, card_valid_n;
   logic                 req_pulse, req_pulse_n;
   logic                 busy, busy_n;
   logic [7:0]           retry_cnt, retry_cnt_n;
   logic [3:0]           wait_cnt, wait_cnt_n;

   logic [2*N_PLAYERS-1:0] req_dbl;
   logic [N_PLAYERS-1:0]   req_rot;
   logic                   req_found;
   logic [PW:0]            req_sum;
   logic [PW-1:0]          req_idx;
   logic [255:0]           dealt_pad;
   logic                   dp_ok;
   logic [7:0]             fb_card;
   logic [7:0]             sel_card;

   // Rotating the request vector by the pointer turns round-robin into a
   // plain lowest-bit search; the found offset is then wrapped back.
   always_comb begin
      req_dbl   = {bus.req_i, bus.req_i};
      req_rot   = req_dbl[rr_ptr +: N_PLAYERS];
      req_found = 1'b0;
      req_sum   = '0;
      for (int k = N_PLAYERS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            req_found = 1'b1;
            req_sum   = {1'b0, rr_ptr} + (PW+1)'(k);
         end
      end
      if (req_sum >= (PW+1)'(N_PLAYERS)) begin
         req_sum = req_sum - (PW+1)'(N_PLAYERS);
      end
      req_idx = req_sum[PW-1:0];
   end

   always_comb begin
      dealt_pad = 256'(dealt);
      dp_ok     = (bus.card_to_send_dp_i < 8'(DECK_SIZE)) &&
                  !dealt_pad[bus.card_to_send_dp_i];
      fb_card   = '0;
      for (int i = DECK_SIZE - 1; i >= 0; i--) begin
         if (!dealt[i]) begin
            fb_card = 8'(i);
         end
      end
      sel_card = dp_ok ? bus.card_to_send_dp_i : fb_card;
   end

   // Next-state and next-output logic; every output is registered from here.
   always_comb begin
      state_n      = state;
      dealt_n      = dealt;
      cards_left_n = cards_left;
      deck_empty_n = deck_empty;
      grant_n      = grant;
      grant_idx_n  = grant_idx;
      rr_ptr_n     = rr_ptr;
      card_n       = card;
      card_valid_n = card_valid;
      req_pulse_n  = 1'b0;
      retry_cnt_n  = retry_cnt;
      wait_cnt_n   = wait_cnt;
      case (state)
         IDLE: begin
            if (bus.shuffle_i) begin
               dealt_n      = '0;
               cards_left_n = 7'(DECK_SIZE);
               deck_empty_n = 1'b0;
            end else if (req_found && !deck_empty) begin
               grant_n     = N_PLAYERS'(1) << req_idx;
               grant_idx_n = req_idx;
               req_pulse_n = 1'b1;
               state_n     = REQ;
            end
         end
         REQ: begin
            wait_cnt_n = '0;
            state_n    = (DP_LATENCY > 1) ? WAIT : CHECK;
         end
         WAIT: begin
            if (wait_cnt == 4'(DP_LATENCY - 2)) begin
               state_n = CHECK;
            end else begin
               wait_cnt_n = wait_cnt + 4'd1;
            end
         end
         CHECK: begin
            if (dp_ok || (retry_cnt >= 8'(MAX_RETRY))) begin
               dealt_n      = dealt | (DECK_SIZE'(1) << sel_card);
               cards_left_n = cards_left - 7'd1;
               deck_empty_n = (cards_left == 7'd1);
               card_n       = sel_card;
               card_valid_n = 1'b1;
               state_n      = DELIVER;
            end else begin
               retry_cnt_n = retry_cnt + 8'd1;
               req_pulse_n = 1'b1;
               state_n     = REQ;
            end
         end
         DELIVER: begin
            if (bus.ack_i) begin
               card_valid_n = 1'b0;
               grant_n      = '0;
               retry_cnt_n  = '0;
               rr_ptr_n     = (grant_idx == PW'(N_PLAYERS - 1)) ? '0 : grant_idx + PW'(1);
               state_n      = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk_ctl_i) begin
      if (!rst_ctl_i) begin
         state      <= IDLE;
         dealt      <= '0;
         cards_left <= 7'(DECK_SIZE);
         deck_empty <= 1'b0;
         grant      <= '0;
         grant_idx  <= '0;
         rr_ptr     <= '0;
         card       <= '0;
         card_valid <= 1'b0;
         req_pulse  <= 1'b0;
         busy       <= 1'b0;
         retry_cnt  <= '0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_n;
         dealt      <= dealt_n;
         cards_left <= cards_left_n;
         deck_empty <= deck_empty_n;
         grant      <= grant_n;
         grant_idx  <= grant_idx_n;
         rr_ptr     <= rr_ptr_n;
         card       <= card_n;
         card_valid <= card_valid_n;
         req_pulse  <= req_pulse_n;
         busy       <= busy_n;
         retry_cnt  <= retry_cnt_n;
         wait_cnt   <= wait_cnt_n;
      end
   end

   assign bus.req_card_state_dp_o = req_pulse;
   assign bus.grant_o             = grant;
   assign bus.card_o              = card;
   assign bus.card_valid_o        = card_valid;
   assign bus.busy_o              = busy;
   assign bus.deck_empty_o        = deck_empty;
   assign bus.cards_left_o        = cards_left;

endmodule

// File: tb/tb_card_dealer_ctrl.sv
// Directed bench for card_dealer_ctrl: a default instance (A) and a slow,
// low-retry instance (B), each fed by a scripted datapath stub.
module tb_card_dealer_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   card_dealer_ctrl_if #(.N_PLAYERS(4)) bus_a ();
   card_dealer_ctrl_if #(.N_PLAYERS(4)) bus_b ();

   card_dealer_ctrl #(.N_PLAYERS(4), .DECK_SIZE(52), .DP_LATENCY(1), .MAX_RETRY(255)) dut_a (
      .clk_ctl_i(clk),
      .rst_ctl_i(rst_n),
      .bus(bus_a)
   );

   card_dealer_ctrl #(.N_PLAYERS(4), .DECK_SIZE(52), .DP_LATENCY(4), .MAX_RETRY(2)) dut_b (
      .clk_ctl_i(clk),
      .rst_ctl_i(rst_n),
      .bus(bus_b)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // Datapath stubs: each advance pulse loads the next scripted value.
   // A falls back to a sequence walking the deck, B sticks at 3.
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [7:0] auto_val = 8'd10;
   int         pulses_a = 0;
   int         pulses_b = 0;

   always @(negedge clk) begin
      if (bus_a.req_card_state_dp_o) begin
         pulses_a++;
         if (q_a.size() > 0) begin
            bus_a.card_to_send_dp_i = q_a.pop_front();
         end else begin
            bus_a.card_to_send_dp_i = auto_val;
            auto_val = (auto_val == 8'd51) ? 8'd0 : auto_val + 8'd1;
         end
      end
      if (bus_b.req_card_state_dp_o) begin
         pulses_b++;
         if (q_b.size() > 0) bus_b.card_to_send_dp_i = q_b.pop_front();
         else                bus_b.card_to_send_dp_i = 8'd3;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [3:0] req, input logic shuffle, input logic ack);
      if (sel == 0) begin
         bus_a.req_i = req; bus_a.shuffle_i = shuffle; bus_a.ack_i = ack;
      end else begin
         bus_b.req_i = req; bus_b.shuffle_i = shuffle; bus_b.ack_i = ack;
      end
   endtask

   task automatic pulseAck(input int sel, input logic [3:0] req);
      applyStimulus(sel, req, 1'b0, 1'b1);
      tick();
      applyStimulus(sel, req, 1'b0, 1'b0);
   endtask

   task automatic waitValid(input int sel, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 2000) begin
         tick();
         cycles++;
         seen = (sel == 0) ? bus_a.card_valid_o : bus_b.card_valid_o;
      end
      if (!seen) checkOutput("valid_timeout", 32'(seen), 32'd1);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int         cyc;
      int         p0;
      logic [3:0] exp_g [5];
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      bus_a.card_to_send_dp_i = 8'd0;
      bus_b.card_to_send_dp_i = 8'd0;
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      doReset();

      $display("[TB] reset state");
      checkOutput("rst_valid", 32'(bus_a.card_valid_o), 0);
      checkOutput("rst_grant", 32'(bus_a.grant_o), 0);
      checkOutput("rst_busy", 32'(bus_a.busy_o), 0);
      checkOutput("rst_pulse", 32'(bus_a.req_card_state_dp_o), 0);
      checkOutput("rst_left", 32'(bus_a.cards_left_o), 52);
      checkOutput("rst_empty", 32'(bus_a.deck_empty_o), 0);
      checkOutput("rst_card", 32'(bus_a.card_o), 0);

      $display("[TB] single deal to player 2");
      q_a.push_back(8'd5);
      p0 = pulses_a;
      applyStimulus(0, 4'b0100, 1'b0, 1'b0);
      tick();
      checkOutput("t1_pulse", 32'(bus_a.req_card_state_dp_o), 1);
      checkOutput("t1_busy", 32'(bus_a.busy_o), 1);
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      waitValid(0, cyc);
      checkOutput("t1_latency", 32'(cyc + 1), 3);
      checkOutput("t1_card", 32'(bus_a.card_o), 5);
      checkOutput("t1_grant", 32'(bus_a.grant_o), 32'b0100);
      checkOutput("t1_left", 32'(bus_a.cards_left_o), 51);
      checkOutput("t1_pulses", 32'(pulses_a - p0), 1);
      tick();
      tick();
      checkOutput("t1_hold_valid", 32'(bus_a.card_valid_o), 1);
      checkOutput("t1_hold_card", 32'(bus_a.card_o), 5);
      pulseAck(0, 4'b0000);
      checkOutput("t1_ack_valid", 32'(bus_a.card_valid_o), 0);
      checkOutput("t1_ack_grant", 32'(bus_a.grant_o), 0);
      checkOutput("t1_ack_busy", 32'(bus_a.busy_o), 0);

      $display("[TB] rejects then accept");
      q_a.push_back(8'd5);
      q_a.push_back(8'd60);
      q_a.push_back(8'd7);
      p0 = pulses_a;
      applyStimulus(0, 4'b0100, 1'b0, 1'b0);
      waitValid(0, cyc);
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      checkOutput("t2_latency", 32'(cyc), 7);
      checkOutput("t2_pulses", 32'(pulses_a - p0), 3);
      checkOutput("t2_card", 32'(bus_a.card_o), 7);
      checkOutput("t2_left", 32'(bus_a.cards_left_o), 50);
      pulseAck(0, 4'b0000);

      $display("[TB] fallback on slow instance");
      q_b.push_back(8'd3);
      p0 = pulses_b;
      applyStimulus(1, 4'b0001, 1'b0, 1'b0);
      waitValid(1, cyc);
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      checkOutput("t4_first_latency", 32'(cyc), 6);
      checkOutput("t4_first_card", 32'(bus_b.card_o), 3);
      checkOutput("t4_first_pulses", 32'(pulses_b - p0), 1);
      pulseAck(1, 4'b0000);
      p0 = pulses_b;
      applyStimulus(1, 4'b0001, 1'b0, 1'b0);
      waitValid(1, cyc);
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      checkOutput("t4_fb_latency", 32'(cyc), 16);
      checkOutput("t4_fb_pulses", 32'(pulses_b - p0), 3);
      checkOutput("t4_fb_card", 32'(bus_b.card_o), 0);
      checkOutput("t4_fb_left", 32'(bus_b.cards_left_o), 50);
      pulseAck(1, 4'b0000);

      $display("[TB] round-robin with all players requesting");
      doReset();
      applyStimulus(0, 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         waitValid(0, cyc);
         checkOutput($sformatf("t3_grant%0d", i), 32'(bus_a.grant_o), 32'(exp_g[i]));
         pulseAck(0, 4'b1111);
      end
      checkOutput("t3_left", 32'(bus_a.cards_left_o), 47);

      $display("[TB] drain the deck");
      for (int i = 0; i < 47; i++) begin
         waitValid(0, cyc);
         if (i == 46) begin
            checkOutput("t5_last_left", 32'(bus_a.cards_left_o), 0);
            checkOutput("t5_last_empty", 32'(bus_a.deck_empty_o), 1);
         end
         pulseAck(0, 4'b1111);
      end
      p0 = pulses_a;
      repeat (6) tick();
      checkOutput("t5_idle_busy", 32'(bus_a.busy_o), 0);
      checkOutput("t5_idle_pulses", 32'(pulses_a - p0), 0);
      checkOutput("t5_idle_empty", 32'(bus_a.deck_empty_o), 1);
      applyStimulus(0, 4'b1111, 1'b1, 1'b0);
      tick();
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      checkOutput("t5_shuf_busy", 32'(bus_a.busy_o), 0);
      checkOutput("t5_shuf_left", 32'(bus_a.cards_left_o), 52);
      checkOutput("t5_shuf_empty", 32'(bus_a.deck_empty_o), 0);
      q_a.push_back(8'd10);
      p0 = pulses_a;
      applyStimulus(0, 4'b0010, 1'b0, 1'b0);
      waitValid(0, cyc);
      applyStimulus(0, 4'b0000, 1'b0, 1'b0);
      checkOutput("t5_redeal_card", 32'(bus_a.card_o), 10);
      checkOutput("t5_redeal_grant", 32'(bus_a.grant_o), 32'b0010);
      checkOutput("t5_redeal_pulses", 32'(pulses_a - p0), 1);
      checkOutput("t5_redeal_left", 32'(bus_a.cards_left_o), 51);
      pulseAck(0, 4'b0000);

      $display("[TB] reset during WAIT");
      applyStimulus(1, 4'b0001, 1'b0, 1'b0);
      tick();
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      tick();
      checkOutput("t6_wait_busy", 32'(bus_b.busy_o), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("t6_busy", 32'(bus_b.busy_o), 0);
      checkOutput("t6_valid", 32'(bus_b.card_valid_o), 0);
      checkOutput("t6_grant", 32'(bus_b.grant_o), 0);
      checkOutput("t6_pulse", 32'(bus_b.req_card_state_dp_o), 0);
      checkOutput("t6_card", 32'(bus_b.card_o), 0);
      checkOutput("t6_left", 32'(bus_b.cards_left_o), 52);
      checkOutput("t6_empty", 32'(bus_b.deck_empty_o), 0);
      repeat (8) tick();
      checkOutput("t6_no_partial", 32'(bus_b.card_valid_o), 0);
      p0 = pulses_b;
      applyStimulus(1, 4'b0001, 1'b0, 1'b0);
      waitValid(1, cyc);
      applyStimulus(1, 4'b0000, 1'b0, 1'b0);
      checkOutput("t6_redeal_latency", 32'(cyc), 6);
      checkOutput("t6_redeal_card", 32'(bus_b.card_o), 3);
      checkOutput("t6_redeal_pulses", 32'(pulses_b - p0), 1);
      checkOutput("t6_redeal_left", 32'(bus_b.cards_left_o), 51);
      pulseAck(1, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
